// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus optional MMIO window (GPIO, cycle counter, TX FIFO, drop counter); MMIO present when DMEM_MMIO_EN is defined.
// Latency: loads are combinational (0 cycles); stores and pushes take effect at the rising edge.
// Backpressure: TX FIFO head is held while TX_READY is low; pushes into a full FIFO are dropped and counted.
module dmem_responder #(
    parameter int ADDR_W     = 10,
    parameter int GPIO_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] DIR_DMEM,
    input  logic [31:0]       DATA_WRITE_DMEM,
    input  logic              READ,
    input  logic              WRITE,
    output logic [31:0]       DATA_READ_DMEM,
    output logic [GPIO_W-1:0] GPIO_OUT,
    output logic [31:0]       TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY
);

    localparam int N = 1 << ADDR_W;

`ifdef DMEM_MMIO_EN
    localparam int RAM_WORDS = N - 8;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);

    logic [31:0]       ram [0:RAM_WORDS-1];
    logic              in_mmio;
    logic [2:0]        reg_sel;
    logic              sel_gpio, sel_cycle, sel_txq, sel_drop;
    logic [GPIO_W-1:0] gpio_q;
    logic [31:0]       cycle_q;
    logic [7:0]        drop_q;
    logic [31:0]       fifo_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [4:0]        count;
    logic              full, tx_vld, pop, push_req, push_ok, drop_inc;

    // The top eight words of the address space form the register window.
    assign in_mmio   = &DIR_DMEM[ADDR_W-1:3];
    assign reg_sel   = DIR_DMEM[2:0];
    assign sel_gpio  = in_mmio && (reg_sel == 3'd0);
    assign sel_cycle = in_mmio && (reg_sel == 3'd1);
    assign sel_txq   = in_mmio && (reg_sel == 3'd2);
    assign sel_drop  = in_mmio && (reg_sel == 3'd3);

    assign full     = (count == 5'(FIFO_DEPTH));
    assign tx_vld   = (count != 5'd0);
    assign pop      = tx_vld && TX_READY;
    assign push_req = WRITE && sel_txq;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);
    assign drop_inc = push_req && full && !pop;

    always_ff @(posedge CLK) begin
        if (WRITE && !in_mmio)
            ram[DIR_DMEM] <= DATA_WRITE_DMEM;
        if (push_ok)
            fifo_mem[wr_ptr] <= DATA_WRITE_DMEM;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            gpio_q  <= '0;
            cycle_q <= '0;
            drop_q  <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            if (WRITE && sel_gpio)
                gpio_q <= DATA_WRITE_DMEM[GPIO_W-1:0];
            if (WRITE && sel_cycle)
                cycle_q <= DATA_WRITE_DMEM;
            else
                cycle_q <= cycle_q + 32'd1;
            if (WRITE && sel_drop)
                drop_q <= '0;
            else if (drop_inc && (drop_q != 8'hFF))
                drop_q <= drop_q + 8'd1;
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        DATA_READ_DMEM = '0;
        if (READ) begin
            if (in_mmio) begin
                case (reg_sel)
                    3'd0:    DATA_READ_DMEM = 32'(gpio_q);
                    3'd1:    DATA_READ_DMEM = cycle_q;
                    3'd2:    DATA_READ_DMEM = {26'b0, count, full};
                    3'd3:    DATA_READ_DMEM = {24'b0, drop_q};
                    default: DATA_READ_DMEM = '0;
                endcase
            end else begin
                DATA_READ_DMEM = ram[DIR_DMEM];
            end
        end
    end

    assign GPIO_OUT = gpio_q;
    assign TX_VALID = tx_vld;
    // Empty storage is never exposed, so the stale words need no reset.
    assign TX_DATA  = tx_vld ? fifo_mem[rd_ptr] : '0;
`else
    logic [31:0] ram [0:N-1];
    logic        unused_inputs;

    always_ff @(posedge CLK) begin
        if (WRITE)
            ram[DIR_DMEM] <= DATA_WRITE_DMEM;
    end

    always_comb begin
        DATA_READ_DMEM = '0;
        if (READ)
            DATA_READ_DMEM = ram[DIR_DMEM];
    end

    assign GPIO_OUT      = '0;
    assign TX_VALID      = 1'b0;
    assign TX_DATA       = '0;
    assign unused_inputs = TX_READY ^ RESET_N;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps then random traffic against a queue/array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 4;
    localparam logic [9:0] A_GPIO  = 10'h3F8;
    localparam logic [9:0] A_CYCLE = 10'h3F9;
    localparam logic [9:0] A_TXQ   = 10'h3FA;
    localparam logic [9:0] A_DROP  = 10'h3FB;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [9:0]  DIR_DMEM;
    logic [31:0] DATA_WRITE_DMEM;
    logic        READ, WRITE, TX_READY;
    logic [31:0] DATA_READ_DMEM;
    logic [15:0] GPIO_OUT;
    logic [31:0] TX_DATA;
    logic        TX_VALID;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_ram [logic [9:0]];
    logic [31:0] m_q [$];
    logic [15:0] m_gpio;
    logic [31:0] m_cyc;
    logic [7:0]  m_drop;

    dmem_responder #(.ADDR_W(10), .GPIO_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DIR_DMEM(DIR_DMEM),
        .DATA_WRITE_DMEM(DATA_WRITE_DMEM), .READ(READ), .WRITE(WRITE),
        .DATA_READ_DMEM(DATA_READ_DMEM), .GPIO_OUT(GPIO_OUT),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_ram(input logic [9:0] a);
`ifdef DMEM_MMIO_EN
        return a < 10'h3F8;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [9:0] a);
        if (is_ram(a))
            return m_ram.exists(a) ? m_ram[a] : 32'hx;
        if (a == A_GPIO)  return {16'h0, m_gpio};
        if (a == A_CYCLE) return m_cyc;
        if (a == A_TXQ)   return {26'b0, 5'(m_q.size()), m_q.size() == DEPTH};
        if (a == A_DROP)  return {24'b0, m_drop};
        return 32'h0;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_gpio = '0;
        m_cyc  = '0;
        m_drop = '0;
    endtask

    task automatic m_edge(input logic wr, input logic [9:0] a, input logic [31:0] d, input logic rdy);
        bit popped;
        popped = (m_q.size() > 0) && rdy;
        if (popped) void'(m_q.pop_front());
        if (wr && is_ram(a)) m_ram[a] = d;
`ifdef DMEM_MMIO_EN
        if (wr && a == A_TXQ) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
        if (wr && a == A_DROP) m_drop = '0;
        if (wr && a == A_GPIO) m_gpio = d[15:0];
        m_cyc = (wr && a == A_CYCLE) ? d : m_cyc + 32'd1;
`endif
    endtask

    // One clock of stimulus: check combinational outputs before the edge, then advance the model.
    task automatic step(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] d, input logic rdy, output logic [31:0] rv);
        READ = rd; WRITE = wr; DIR_DMEM = a; DATA_WRITE_DMEM = d; TX_READY = rdy;
        #1;
        rv = DATA_READ_DMEM;
        chk("rdata", DATA_READ_DMEM, rd ? m_read(a) : 32'h0);
        chk("gpio", {16'h0, GPIO_OUT}, {16'h0, m_gpio});
        chk("tx_valid", {31'h0, TX_VALID}, {31'h0, m_q.size() != 0});
        chk("tx_data", TX_DATA, (m_q.size() != 0) ? m_q[0] : 32'h0);
        @(posedge CLK);
        m_edge(wr, a, d, rdy);
        #1;
    endtask

    initial begin
        logic [31:0] rv;
        logic [9:0]  pool [16];

        RESET_N = 1'b0; READ = 0; WRITE = 0; DIR_DMEM = '0; DATA_WRITE_DMEM = '0; TX_READY = 0;
        m_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_txv", {31'h0, TX_VALID}, 32'h0);
        chk("rst_txd", TX_DATA, 32'h0);
        chk("rst_gpio", {16'h0, GPIO_OUT}, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 16; i++) pool[i] = (i < 8) ? 10'(i) : 10'(10'h3F8 + i - 8);
        for (int i = 0; i < 8; i++) step(0, 1, 10'(i), $urandom, 0, rv);

        // RAM read-after-write and read-during-write
        step(0, 1, 10'd5, 32'hDEADBEEF, 0, rv);
        step(1, 0, 10'd5, 32'h0, 0, rv);
        chk("ram_rd", rv, 32'hDEADBEEF);
        step(0, 0, 10'd5, 32'h0, 0, rv);
        chk("ram_noread", rv, 32'h0);
        step(1, 1, 10'd5, 32'h1, 0, rv);
        chk("ram_rdw_old", rv, 32'hDEADBEEF);
        step(1, 0, 10'd5, 32'h0, 0, rv);
        chk("ram_rdw_new", rv, 32'h1);

`ifdef DMEM_MMIO_EN
        step(0, 1, A_GPIO, 32'h12345, 0, rv);
        chk("gpio_load", {16'h0, GPIO_OUT}, 32'h2345);
        step(0, 1, A_CYCLE, 32'hFFFFFFFE, 0, rv);
        step(1, 0, A_CYCLE, 32'h0, 0, rv);
        chk("cyc_load", rv, 32'hFFFFFFFE);
        step(1, 0, A_CYCLE, 32'h0, 0, rv);
        chk("cyc_max", rv, 32'hFFFFFFFF);
        step(1, 0, A_CYCLE, 32'h0, 0, rv);
        chk("cyc_wrap", rv, 32'h0);

        for (int i = 1; i <= 5; i++) step(0, 1, A_TXQ, 32'(i), 0, rv);
        step(1, 0, A_TXQ, 32'h0, 0, rv);
        chk("fill_status", rv, 32'h9);
        step(1, 0, A_DROP, 32'h0, 0, rv);
        chk("fill_drop", rv, 32'h1);
        chk("fill_head", TX_DATA, 32'h1);
        step(0, 1, A_DROP, 32'hFFFF, 0, rv);
        step(1, 0, A_DROP, 32'h0, 0, rv);
        chk("drop_clr", rv, 32'h0);

        for (int i = 1; i <= 4; i++) begin
            chk("drain_head", TX_DATA, 32'(i));
            step(0, 0, 10'd0, 32'h0, 1, rv);
        end
        chk("drain_empty", {31'h0, TX_VALID}, 32'h0);
        step(1, 0, A_TXQ, 32'h0, 0, rv);
        chk("drain_status", rv, 32'h0);

        for (int i = 0; i < 4; i++) step(0, 1, A_TXQ, 32'h100 + 32'(i), 0, rv);
        step(0, 1, A_TXQ, 32'h99, 1, rv);
        step(1, 0, A_TXQ, 32'h0, 0, rv);
        chk("pushpop_full", rv, 32'h9);
        step(1, 0, A_DROP, 32'h0, 0, rv);
        chk("pushpop_drop", rv, 32'h0);
        step(0, 1, 10'h3FC, 32'hFFFF, 0, rv);
        step(1, 0, 10'h3FC, 32'h0, 0, rv);
        chk("reserved", rv, 32'h0);

        step(0, 0, 10'd0, 32'h0, 1, rv);
        step(0, 1, A_GPIO, 32'hAA, 0, rv);
        chk("pre_rst_gpio", {16'h0, GPIO_OUT}, 32'hAA);
        chk("pre_rst_txv", {31'h0, TX_VALID}, 32'h1);
`endif

        // Asynchronous reset between edges
        #2;
        WRITE = 0; READ = 1; DIR_DMEM = A_CYCLE; TX_READY = 0;
        RESET_N = 1'b0;
        #1;
        chk("arst_txv", {31'h0, TX_VALID}, 32'h0);
        chk("arst_gpio", {16'h0, GPIO_OUT}, 32'h0);
`ifdef DMEM_MMIO_EN
        chk("arst_cyc", DATA_READ_DMEM, 32'h0);
`endif
        DIR_DMEM = 10'd5;
        #1;
        chk("arst_ram", DATA_READ_DMEM, 32'h1);
        m_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
`ifdef DMEM_MMIO_EN
        step(1, 0, A_CYCLE, 32'h0, 0, rv);
        chk("cyc_first", rv, 32'h0);
        step(1, 0, A_CYCLE, 32'h0, 0, rv);
        chk("cyc_second", rv, 32'h1);
`else
        for (int i = 8; i < 16; i++) step(0, 1, pool[i], $urandom, 0, rv);
        step(0, 1, A_GPIO, 32'h55, 0, rv);
        step(1, 0, A_GPIO, 32'h0, 0, rv);
        chk("nommio_ram", rv, 32'h55);
        chk("nommio_gpio", {16'h0, GPIO_OUT}, 32'h0);
        chk("nommio_txv", {31'h0, TX_VALID}, 32'h0);
`endif

        for (int i = 0; i < 600; i++)
            step(1'($urandom % 2), 1'($urandom % 3 == 0), pool[$urandom_range(0, 15)],
                 $urandom, 1'($urandom % 2), rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
